// File: rtl/sdram_cache_pkg.sv
// Shared definitions for the SDRAM write-through cache: FSM encoding,
// default geometry and address field extraction.
package sdram_cache_pkg;

    localparam int DEF_LINES      = 256;
    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_ADDR_WIDTH = 32;

    localparam int OFFSET_BITS = $clog2(DEF_LINE_WORDS);
    localparam int INDEX_BITS  = $clog2(DEF_LINES);
    localparam int TAG_BITS    = DEF_ADDR_WIDTH - 2 - OFFSET_BITS - INDEX_BITS;

    typedef enum logic [2:0] {
        ST_INV,
        ST_IDLE,
        ST_LOOKUP,
        ST_FILL,
        ST_RESP,
        ST_WRITE,
        ST_DONE
    } state_e;

    // Extract 'bits' bits of a byte address starting at bit 'lsb'; zero bits yields 0.
    function automatic logic [63:0] addr_field(input logic [63:0] a,
                                               input int unsigned lsb,
                                               input int unsigned bits);
        return (a >> lsb) & ((64'd1 << bits) - 64'd1);
    endfunction

endpackage

// File: rtl/cache_data_ram.sv
// Simple dual-port RAM: synchronous read, byte-lane write enables; a read of
// the address being written returns the old contents.
module cache_data_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024
) (
    input  logic                       clk_i,
    input  logic [$clog2(DEPTH)-1:0]   raddr_i,
    output logic [WIDTH-1:0]           rdata_o,
    input  logic [(WIDTH+7)/8-1:0]     we_i,
    input  logic [$clog2(DEPTH)-1:0]   waddr_i,
    input  logic [WIDTH-1:0]           wdata_i
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        rdata_o <= mem[raddr_i];
        for (int i = 0; i < WIDTH; i++) begin
            if (we_i[i/8]) mem[waddr_i][i] <= wdata_i[i];
        end
    end

endmodule

// File: rtl/sdram_wt_cache.sv
// Direct-mapped, write-through, no-write-allocate cache in front of the SDRAM
// controller. Read misses fetch the whole line; writes always go downstream.
module sdram_wt_cache
    import sdram_cache_pkg::*;
#(
    parameter int LINES      = DEF_LINES,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [ADDR_WIDTH-1:0] s_addr,
    input  logic [31:0]           s_wdata,
    input  logic [3:0]            s_wstrb,
    output logic [31:0]           s_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [31:0]           m_wdata,
    output logic [3:0]            m_wstrb,
    input  logic [31:0]           m_rdata,
    input  logic                  flush,
    output logic                  busy,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    localparam int OB  = $clog2(LINE_WORDS);
    localparam int IB  = $clog2(LINES);
    localparam int TB  = ADDR_WIDTH - 2 - OB - IB;
    localparam int RAW = OB + IB;
    localparam int FCW = OB + 1;
    localparam int TNB = (TB + 7) / 8;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  hit_q, hit_d;
    logic [FCW-1:0]        fcnt_q, fcnt_d;
    logic [IB-1:0]         inv_q, inv_d;
    logic                  flush_pend_q, flush_pend_d;
    logic                  s_ready_q, s_ready_d;
    logic [31:0]           s_rdata_q, s_rdata_d;
    logic                  m_valid_q, m_valid_d;
    logic [31:0]           hit_cnt_q, hit_cnt_d;
    logic [31:0]           miss_cnt_q, miss_cnt_d;
    logic [LINES-1:0]      valid_q;

    logic                  vclr, vset, fill_last, lookup_hit;
    logic [IB-1:0]         idx_q;
    logic [TB-1:0]         tag_q, tag_rdata;
    logic [FCW-1:0]        off_q;
    logic [ADDR_WIDTH-1:0] line_base;
    logic [RAW-1:0]        drd_addr, dwaddr;
    logic [31:0]           drd_data, dwdata;
    logic [3:0]            dwe;
    logic [IB-1:0]         trd_addr;

    assign idx_q     = IB'(addr_field(64'(addr_q), 2 + OB, IB));
    assign tag_q     = TB'(addr_field(64'(addr_q), 2 + OB + IB, TB));
    assign off_q     = FCW'(addr_field(64'(addr_q), 2, OB));
    assign line_base = addr_q & ~ADDR_WIDTH'(LINE_WORDS * 4 - 1);

    // RAMs are always addressed from the live request so the IDLE cycle's read lands in LOOKUP.
    assign drd_addr  = RAW'(addr_field(64'(s_addr), 2, RAW));
    assign trd_addr  = IB'(addr_field(64'(s_addr), 2 + OB, IB));
    assign dwaddr    = RAW'(addr_field(64'(m_addr), 2, RAW));
    assign dwdata    = (state_q == ST_FILL) ? m_rdata : wdata_q;

    assign lookup_hit = valid_q[idx_q] && (tag_rdata == tag_q);

    assign s_ready    = s_ready_q;
    assign s_rdata    = s_rdata_q;
    assign m_valid    = m_valid_q;
    assign m_addr     = (state_q == ST_FILL) ? (line_base | (ADDR_WIDTH'(fcnt_q) << 2)) : addr_q;
    assign m_wdata    = wdata_q;
    assign m_wstrb    = (state_q == ST_WRITE) ? wstrb_q : 4'h0;
    assign busy       = (state_q != ST_IDLE);
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

    cache_data_ram #(.WIDTH(32), .DEPTH(LINES * LINE_WORDS)) u_data (
        .clk_i   (clk),
        .raddr_i (drd_addr),
        .rdata_o (drd_data),
        .we_i    (dwe),
        .waddr_i (dwaddr),
        .wdata_i (dwdata)
    );

    cache_data_ram #(.WIDTH(TB), .DEPTH(LINES)) u_tag (
        .clk_i   (clk),
        .raddr_i (trd_addr),
        .rdata_o (tag_rdata),
        .we_i    ({TNB{fill_last}}),
        .waddr_i (idx_q),
        .wdata_i (tag_q)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        hit_d        = hit_q;
        fcnt_d       = fcnt_q;
        inv_d        = inv_q;
        flush_pend_d = flush_pend_q | flush;
        s_ready_d    = 1'b0;
        s_rdata_d    = s_rdata_q;
        m_valid_d    = m_valid_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        vclr         = 1'b0;
        vset         = 1'b0;
        fill_last    = 1'b0;
        dwe          = 4'h0;
        case (state_q)
            ST_INV: begin
                vclr  = 1'b1;
                inv_d = inv_q + 1'b1;
                if (inv_q == IB'(LINES - 1)) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (flush_pend_q || flush) begin
                    flush_pend_d = 1'b0;
                    inv_d        = '0;
                    state_d      = ST_INV;
                end else if (s_valid) begin
                    addr_d  = s_addr & ~ADDR_WIDTH'(3);
                    wdata_d = s_wdata;
                    wstrb_d = s_wstrb;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                hit_d = lookup_hit;
                if (wstrb_q != 4'h0) begin
                    m_valid_d = 1'b1;
                    state_d   = ST_WRITE;
                end else if (lookup_hit) begin
                    s_rdata_d = drd_data;
                    s_ready_d = 1'b1;
                    hit_cnt_d = hit_cnt_q + 32'd1;
                    state_d   = ST_DONE;
                end else begin
                    miss_cnt_d = miss_cnt_q + 32'd1;
                    fcnt_d     = '0;
                    m_valid_d  = 1'b1;
                    state_d    = ST_FILL;
                end
            end
            ST_FILL: begin
                if (m_valid_q && m_ready) begin
                    m_valid_d = 1'b0;
                    dwe       = 4'hF;
                    fcnt_d    = fcnt_q + 1'b1;
                    if (fcnt_q == off_q) s_rdata_d = m_rdata;
                    if (fcnt_q == FCW'(LINE_WORDS - 1)) begin
                        fill_last = 1'b1;
                        vset      = 1'b1;
                        state_d   = ST_RESP;
                    end
                end else if (!m_valid_q) begin
                    m_valid_d = 1'b1;
                end
            end
            ST_RESP: begin
                s_ready_d = 1'b1;
                state_d   = ST_DONE;
            end
            ST_WRITE: begin
                if (m_valid_q && m_ready) begin
                    // No-write-allocate: only a line that hit in LOOKUP is updated.
                    if (hit_q) dwe = wstrb_q;
                    m_valid_d = 1'b0;
                    s_ready_d = 1'b1;
                    s_rdata_d = 32'h0;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_INV;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_INV;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            hit_q        <= 1'b0;
            fcnt_q       <= '0;
            inv_q        <= '0;
            flush_pend_q <= 1'b0;
            s_ready_q    <= 1'b0;
            s_rdata_q    <= '0;
            m_valid_q    <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            hit_q        <= hit_d;
            fcnt_q       <= fcnt_d;
            inv_q        <= inv_d;
            flush_pend_q <= flush_pend_d;
            s_ready_q    <= s_ready_d;
            s_rdata_q    <= s_rdata_d;
            m_valid_q    <= m_valid_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    // Valid bits need no reset of their own: reset always passes through the INV sweep.
    always_ff @(posedge clk) begin
        if (vclr) valid_q[inv_q] <= 1'b0;
        if (vset) valid_q[idx_q] <= 1'b1;
    end

endmodule

// File: tb/tb_sdram_wt_cache.sv
// Scoreboard bench for sdram_wt_cache: a reference cache/memory model predicts
// downstream requests and CPU responses; a random-latency SDRAM model answers.
module tb_sdram_wt_cache;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_addr = '0;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic [31:0] s_rdata;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [31:0] m_rdata = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    always #5 clk = ~clk;

    sdram_wt_cache dut (
        .clk(clk), .resetn(resetn),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_rdata(s_rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_rdata(m_rdata),
        .flush(flush), .busy(busy), .hit_count(hit_count), .miss_count(miss_count)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mreq_t;

    int          total = 0;
    int          bad = 0;
    mreq_t       exp_m[$];
    logic [31:0] exp_s[$];
    bit          rv[256];
    logic [19:0] rt[256];
    logic [31:0] ref_mem[int unsigned];
    logic [31:0] sd_mem[int unsigned];
    int          exp_hits = 0;
    int          exp_miss = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] wa);
        return (wa * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] wa);
        return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
    endfunction

    // Reference: memory always holds the truth; the cache only decides hit/miss traffic.
    task automatic ref_issue(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wstrb, output bit hit);
        logic [31:0] wa;
        int          idx;
        logic [19:0] tag;
        mreq_t       e;
        wa  = addr >> 2;
        idx = int'((addr >> 4) & 32'hFF);
        tag = 20'(addr >> 12);
        hit = rv[idx] && (rt[idx] == tag);
        if (wstrb == 4'h0) begin
            exp_s.push_back(ref_rd(wa));
            if (hit) exp_hits++;
            else begin
                exp_miss++;
                for (int k = 0; k < 4; k++) begin
                    e.addr = (addr & ~32'hF) + 32'(4 * k);
                    e.wdata = '0;
                    e.wstrb = 4'h0;
                    exp_m.push_back(e);
                end
                rv[idx] = 1'b1;
                rt[idx] = tag;
            end
        end else begin
            e.addr = addr & ~32'h3;
            e.wdata = wdata;
            e.wstrb = wstrb;
            exp_m.push_back(e);
            ref_mem[wa] = merge(ref_rd(wa), wdata, wstrb);
            exp_s.push_back(32'h0);
        end
    endtask

    // flush_at: -1 none, 0 together with s_valid, k>0 pulse k cycles into the transaction.
    task automatic cpu_req(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input int flush_at);
        bit h;
        bit pulsed;
        bit done;
        int cyc;
        pulsed = 1'b0;
        if (flush_at == 0) foreach (rv[i]) rv[i] = 1'b0;
        ref_issue(addr, wdata, wstrb, h);
        s_addr = addr;
        s_wdata = wdata;
        s_wstrb = wstrb;
        s_valid = 1'b1;
        if (flush_at == 0) flush = 1'b1;
        cyc = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            flush = 1'b0;
            cyc++;
            if (s_ready) done = 1'b1;
            else if (cyc == flush_at) begin
                flush = 1'b1;
                pulsed = 1'b1;
            end else if (cyc > 700) begin
                total++;
                bad++;
                $display("FAIL s_timeout addr=%h waited=%0d limit=700", addr, cyc);
                done = 1'b1;
            end
        end
        s_valid = 1'b0;
        if (wstrb == 4'h0 && h && flush_at < 0) chk("hit_latency", cyc, 2);
        if (pulsed) foreach (rv[i]) rv[i] = 1'b0;
        @(negedge clk);
    endtask

    // Called from the IDLE cycle that follows a flushed transaction.
    task automatic check_sweep(input string nm);
        int n;
        @(negedge clk);
        n = 0;
        while (busy && n < 600) begin
            n++;
            @(negedge clk);
        end
        chk(nm, n, 256);
    endtask

    initial begin : sdram_model
        int          dly;
        mreq_t       e;
        logic [31:0] wa;
        dly = -1;
        forever begin
            @(negedge clk);
            if (m_ready) begin
                m_ready = 1'b0;
                chk("m_valid_drop", m_valid, 1'b0);
            end else if (!resetn) begin
                dly = -1;
            end else if (m_valid) begin
                if (dly < 0) begin
                    dly = int'($urandom_range(0, 3));
                    if (exp_m.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL m_unexpected: got request addr=%h wstrb=%h expected none",
                                 m_addr, m_wstrb);
                    end else begin
                        e = exp_m.pop_front();
                        chk("m_addr", m_addr, e.addr);
                        chk("m_wstrb", 32'(m_wstrb), 32'(e.wstrb));
                        if (e.wstrb != 4'h0) chk("m_wdata", m_wdata, e.wdata);
                    end
                end
                if (dly == 0) begin
                    wa = m_addr >> 2;
                    m_rdata = sd_mem.exists(wa) ? sd_mem[wa] : init_word(wa);
                    if (m_wstrb != 4'h0) sd_mem[wa] = merge(m_rdata, m_wdata, m_wstrb);
                    m_ready = 1'b1;
                    dly = -1;
                end else begin
                    dly--;
                end
            end
        end
    end

    initial begin : s_monitor
        bit prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (resetn && s_ready) begin
                if (exp_s.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL s_unexpected: got s_ready with rdata=%h expected none", s_rdata);
                end else begin
                    chk("s_rdata", s_rdata, exp_s.pop_front());
                end
                chk("s_ready_pulse", 32'(prev), 32'(0));
            end
            prev = s_ready;
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        foreach (rv[i]) rv[i] = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_wstrb", 32'(m_wstrb), 0);
        chk("rst_s_rdata", s_rdata, 0);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_miss_count", miss_count, 0);
        chk("rst_busy", busy, 1);
        resetn = 1'b1;
        n = 0;
        while (busy && n < 600) begin
            n++;
            @(negedge clk);
        end
        chk("rst_sweep_len", n, 256);

        cpu_req(32'h8000_0010, 32'h0, 4'h0, -1);
        chk("first_miss_count", miss_count, 1);
        cpu_req(32'h8000_0014, 32'h0, 4'h0, -1);
        chk("first_hit_count", hit_count, 1);
        cpu_req(32'h8000_0015, 32'h0000_A500, 4'b0010, -1);
        cpu_req(32'h8000_0014, 32'h0, 4'h0, -1);
        chk("merged_hit_count", hit_count, 2);

        cpu_req(32'h8000_4000, 32'hCAFE_F00D, 4'hF, -1);
        cpu_req(32'h8000_4000, 32'h0, 4'h0, -1);
        chk("no_alloc_miss_count", miss_count, 2);

        cpu_req(32'h8000_0000, 32'h0, 4'h0, -1);
        cpu_req(32'h8000_1000, 32'h0, 4'h0, -1);
        cpu_req(32'h8000_0000, 32'h0, 4'h0, -1);
        chk("alias_miss_count", miss_count, 5);

        cpu_req(32'h8000_2000, 32'h0, 4'h0, 3);
        check_sweep("flush_sweep_len");
        cpu_req(32'h8000_2000, 32'h0, 4'h0, -1);
        chk("post_flush_miss_count", miss_count, 7);

        cpu_req(32'h8000_2004, 32'h0, 4'h0, -1);
        cpu_req(32'h8000_2004, 32'h0, 4'h0, 0);
        chk("flush_with_req_miss_count", miss_count, 8);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            logic [3:0]  st;
            int          fa;
            a  = 32'h8000_0000 | ($urandom_range(0, 2) << 12) | ($urandom_range(0, 7) << 4)
                 | $urandom_range(0, 15);
            st = ($urandom_range(0, 9) < 6) ? 4'h0 : 4'($urandom_range(1, 15));
            fa = ($urandom_range(0, 24) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 3) : -1;
            cpu_req(a, $urandom, st, fa);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("final_hit_count", hit_count, 32'(exp_hits));
        chk("final_miss_count", miss_count, 32'(exp_miss));
        chk("exp_m_drained", 32'(exp_m.size()), 0);
        chk("exp_s_drained", 32'(exp_s.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
